// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the branch predictor: branch-type codes,
// 2-bit counter states and the saturating performance-counter helper.
package branch_predictor_pkg;

    localparam int unsigned BR_W   = 3;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned PERF_W = 32;

    typedef enum logic [BR_W-1:0] {
        BR_NONE = 3'b000,
        BR_JAL  = 3'b001,
        BR_JALR = 3'b010,
        BR_RSV  = 3'b011,
        BR_BEQ  = 3'b100,
        BR_BNE  = 3'b101,
        BR_BLT  = 3'b110,
        BR_BGE  = 3'b111
    } br_type_e;

    typedef enum logic [CNT_W-1:0] {
        CNT_SNT = 2'b00,
        CNT_WNT = 2'b01,
        CNT_WT  = 2'b10,
        CNT_ST  = 2'b11
    } cnt_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
        return (en && (v != '1)) ? PERF_W'(v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side prediction, resolve-side feedback and perf-counter bundle
// between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(
    parameter int unsigned XLEN = 32
);
    import branch_predictor_pkg::*;

    logic [XLEN-1:0]   pc_f;
    logic              pred_taken;
    logic [XLEN-1:0]   pred_target;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_target;
    logic [BR_W-1:0]   ex_branch;
    logic              ex_zero;
    logic              ex_result0;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pred_target;

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [PERF_W-1:0] br_count;
    logic [PERF_W-1:0] mispred_count;

    modport master (
        output pc_f, ex_valid, ex_pc, ex_target, ex_branch, ex_zero, ex_result0,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect_valid, redirect_pc, br_count, mispred_count
    );

    modport slave (
        input  pc_f, ex_valid, ex_pc, ex_target, ex_branch, ex_zero, ex_result0,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect_valid, redirect_pc, br_count, mispred_count
    );

endinterface

// File: rtl/branch_cond.sv
// Combinational resolve decoder: turns branch type plus ALU flags into
// taken / is-a-branch / unconditional indications.
module branch_cond
    import branch_predictor_pkg::*;
(
    input  logic [BR_W-1:0] br_type,
    input  logic            zero,
    input  logic            result0,
    output logic            taken_c,
    output logic            is_branch_c,
    output logic            uncond_c
);

    always_comb begin
        taken_c     = 1'b0;
        is_branch_c = 1'b1;
        uncond_c    = 1'b0;
        case (br_type)
            BR_JAL, BR_JALR: begin
                taken_c  = 1'b1;
                uncond_c = 1'b1;
            end
            BR_BEQ:  taken_c = zero;
            BR_BNE:  taken_c = ~zero;
            BR_BLT:  taken_c = result0;
            // bge is taken on equality or when "less than" came out false
            BR_BGE:  taken_c = zero | ~result0;
            default: is_branch_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit counters, resolve-stage
// mispredict detection, registered redirect and saturating perf counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16
) (
    input logic               clk,
    input logic               rst_n,
    branch_predictor_if.slave bus
);

    localparam int unsigned IDX  = $clog2(ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic             valid_q  [ENTRIES];
    logic [TAGW-1:0]  tag_q    [ENTRIES];
    logic [XLEN-1:0]  tgt_q    [ENTRIES];
    logic [CNT_W-1:0] cnt_q    [ENTRIES];
    logic             uncond_q [ENTRIES];

    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic [PERF_W-1:0] br_q;
    logic [PERF_W-1:0] mispred_q;
    logic [PERF_W-1:0] br_d;
    logic [PERF_W-1:0] mispred_d;

    logic [IDX-1:0]  idx_f;
    logic [TAGW-1:0] tag_f;
    logic            hit_f;
    logic            pred_taken_c;

    logic [IDX-1:0]  ex_idx;
    logic [TAGW-1:0] ex_tag;
    logic            taken;
    logic            is_branch;
    logic            is_uncond;
    logic [XLEN-1:0] actual_pc;
    logic            mispredict;
    logic            upd_en;
    logic            hit_e;

    logic [CNT_W-1:0] new_cnt;
    logic [XLEN-1:0]  new_tgt;
    logic             new_unc;

    branch_cond u_cond (
        .br_type     (bus.ex_branch),
        .zero        (bus.ex_zero),
        .result0     (bus.ex_result0),
        .taken_c     (taken),
        .is_branch_c (is_branch),
        .uncond_c    (is_uncond)
    );

    // Fetch-side lookup reads the registered table only, so a same-cycle
    // update is not visible until the next cycle.
    assign idx_f        = bus.pc_f[IDX+1:2];
    assign tag_f        = bus.pc_f[XLEN-1:IDX+2];
    assign hit_f        = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign pred_taken_c = hit_f && (uncond_q[idx_f] || cnt_q[idx_f][1]);

    assign bus.pred_taken  = pred_taken_c;
    assign bus.pred_target = pred_taken_c ? tgt_q[idx_f] : XLEN'(bus.pc_f + XLEN'(4));

    // Resolve-side outcome and mispredict detection.
    assign ex_idx     = bus.ex_pc[IDX+1:2];
    assign ex_tag     = bus.ex_pc[XLEN-1:IDX+2];
    assign actual_pc  = taken ? bus.ex_target : XLEN'(bus.ex_pc + XLEN'(4));
    assign mispredict = bus.ex_valid &&
                        ((bus.ex_pred_taken != taken) ||
                         (taken && (bus.ex_pred_target != bus.ex_target)));
    assign upd_en     = bus.ex_valid && is_branch;
    assign hit_e      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Next contents of the entry being trained.
    always_comb begin
        new_cnt = cnt_q[ex_idx];
        new_tgt = tgt_q[ex_idx];
        new_unc = uncond_q[ex_idx];
        if (is_uncond) begin
            new_cnt = CNT_ST;
            new_tgt = bus.ex_target;
            new_unc = 1'b1;
        end else if (hit_e) begin
            if (taken) begin
                new_tgt = bus.ex_target;
                if (cnt_q[ex_idx] != CNT_ST) begin
                    new_cnt = CNT_W'(cnt_q[ex_idx] + 1'b1);
                end
            end else if (cnt_q[ex_idx] != CNT_SNT) begin
                new_cnt = CNT_W'(cnt_q[ex_idx] - 1'b1);
            end
        end else begin
            new_cnt = taken ? CNT_WT : CNT_WNT;
            new_tgt = bus.ex_target;
            new_unc = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                tgt_q[i]    <= '0;
                cnt_q[i]    <= CNT_WNT;
                uncond_q[i] <= 1'b0;
            end
        end else if (upd_en) begin
            valid_q[ex_idx]  <= 1'b1;
            tag_q[ex_idx]    <= ex_tag;
            tgt_q[ex_idx]    <= new_tgt;
            cnt_q[ex_idx]    <= new_cnt;
            uncond_q[ex_idx] <= new_unc;
        end
    end

    assign br_d      = sat_inc(br_q, upd_en);
    assign mispred_d = sat_inc(mispred_q, mispredict);

    // Redirect pulse and perf counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_q             <= '0;
            mispred_q        <= '0;
        end else begin
            redirect_valid_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual_pc;
            end
            br_q      <= br_d;
            mispred_q <= mispred_d;
        end
    end

    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.br_count       = br_q;
    assign bus.mispred_count  = mispred_q;

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC/target width.
REQ-002 SHALL have parameter ENTRIES, default 16: table depth, power of 2 and at least 2; IDX = log2(ENTRIES).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port pc_f, input, XLEN: fetch PC to be predicted.
REQ-006 SHALL have port pred_taken, output, 1: fetch prediction.
REQ-007 SHALL have port pred_target, output, XLEN: predicted next PC.
REQ-008 SHALL have port ex_valid, input, 1: resolve-stage instruction valid.
REQ-009 SHALL have ex_pc and ex_target, input, XLEN each: resolve PC and computed target.
REQ-010 SHALL have port ex_branch, input, 3: branch type. 000 none; 001 jal; 010 jalr; 100 beq; 101 bne; 110 blt/bltu; 111 bge/bgeu.
REQ-011 SHALL have ports ex_zero and ex_result0, input, 1 each: ALU zero flag and ALU result bit 0.
REQ-012 SHALL have ex_pred_taken (1) and ex_pred_target (XLEN), inputs: the prediction carried down the pipe.
REQ-013 SHALL have outputs redirect_valid (1) and redirect_pc (XLEN): registered misprediction redirect.
REQ-014 SHALL have outputs br_count and mispred_count, 32 bits each: performance counters.

Function
REQ-015 SHALL hold ENTRIES entries, each with valid, tag, target, 2-bit counter and uncond bit.
  - index = pc[IDX+1:2]
  - tag = pc[XLEN-1:IDX+2]
REQ-016 SHALL compute pred_taken combinationally as: entry valid AND tag match AND (uncond OR cnt[1]).
  - pred_target = entry target when pred_taken, else pc_f+4.
REQ-017 SHALL compute the resolve outcome "taken" as follows.
  - Type 001/010: 1.
  - Type 100: ex_zero.
  - Type 101: ~ex_zero.
  - Type 110: ex_result0.
  - Type 111: ex_zero | ~ex_result0.
  - Types 000 and 011: not a branch.
REQ-018 SHALL set actual_pc = taken ? ex_target : ex_pc+4, with XLEN wrap-around on the +4.
REQ-019 SHALL declare a mispredict when ex_valid and (ex_pred_taken != taken, or (taken and ex_pred_target != ex_target)).
  - This includes a non-branch predicted taken, which redirects to ex_pc+4.
REQ-020 SHALL assert redirect_valid for exactly one cycle, in the cycle after the mispredict, with redirect_pc = actual_pc registered.
REQ-021 SHALL update the table on ex_valid with a branch type (not 000/011), at the ex_pc index.
  - Tag hit, conditional branch: cnt saturating +1 if taken, -1 if not taken (11 and 00 hold); target written only if taken.
  - Tag miss, conditional branch: allocate with valid=1, tag, target=ex_target, cnt = taken ? 10 : 01.
  - Jal/jalr, hit or miss: write valid=1, uncond=1, cnt=11, target=ex_target.
REQ-022 SHALL never update the table for non-branch types or when ex_valid=0.
REQ-023 SHALL make a same-cycle predict and update to the same index return the pre-update entry (no bypass).
REQ-024 SHALL increment br_count by 1 per valid branch, and mispred_count by 1 per mispredict; both saturate at all-ones.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear all state.
  - All valid bits = 0; all counters = 01.
  - redirect_valid = 0, redirect_pc = 0.
  - br_count = 0, mispred_count = 0.
REQ-026 SHALL, when reset is asserted mid-operation, discard any pending redirect: redirect_valid = 0 in the following cycle.

Structure
REQ-027 SHALL take branch-type encodings and counter state constants (SNT=00, WNT=01, WT=10, ST=11) from the shared package.
REQ-028 SHALL instantiate one sub-module, branch_cond, a combinational taken/not-branch decoder implementing REQ-017.

Verification
REQ-029 SHALL cover reset then pc_f=0x100: pred_taken=0, pred_target=0x104.
REQ-030 SHALL cover beq at 0x100, ex_zero=1, target 0x80, ex_pred_taken=0.
  - Next cycle: redirect_valid=1 for one cycle, redirect_pc=0x80.
  - Entry allocated with cnt=10; then pc_f=0x100 gives pred_taken=1, pred_target=0x80.
REQ-031 SHALL cover bne resolved not-taken 3 times after allocation: cnt goes 10 -> 01 -> 00 -> 00 (saturation) and pred_taken=0.
REQ-032 SHALL cover type 000 with ex_pred_taken=1 at ex_pc=0xFFFFFFFC: redirect_pc=0x00000000, and no table update.
REQ-033 SHALL cover a jal update and a fetch of the same index in the same cycle: pred_taken=0 that cycle, 1 the next.
REQ-034 SHALL cover mispred_count preloaded at 0xFFFFFFFF plus one more mispredict: the count stays 0xFFFFFFFF, and rst_n=0 then clears it to 0.
